uart_hex_transmitter: RTL and testbench

- Downstream consumer of the UART input manager's assembled DIGIT_COUNT*4-bit word and its ready pulse; echoes the value back to the host as ASCII hex over the board's TX line (RsTx).
- Snapshots the word on a start pulse and converts each nibble to an uppercase ASCII hex character.
- Serialises each character as 8N1 at BAUD_RATE, optionally followed by CR LF.
- Contains its own baud counter, bit-level TX FSM and character sequencer; no external UART TX module.

---
 rtl/uart_hex_transmitter.sv | 140 ++++++++++++++
 tb/tb_uart_hex_transmitter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_transmitter.sv
// rtl/uart_hex_transmitter.sv - echoes a captured word as uppercase ASCII hex over an 8N1 serial line
module uart_hex_transmitter #(
  parameter int CLOCK_RATE  = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int DIGIT_COUNT = 4,
  parameter int APPEND_CRLF = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DIGIT_COUNT*4-1:0] data_in,
  input  logic                     start,
  output logic                     RsTx,
  output logic                     busy,
  output logic                     done
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int N_CHARS      = DIGIT_COUNT + 2 * APPEND_CRLF;
  localparam int CHAR_W       = $clog2(N_CHARS + 1);
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CHAR_W-1:0] CHAR_LAST  = CHAR_W'(N_CHARS - 1);
  localparam logic [CHAR_W-1:0] CHAR_CR    = CHAR_W'(DIGIT_COUNT);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t                   state, state_d;
  logic [BAUD_W-1:0]        baud, baud_d;
  logic [2:0]               bit_idx, bit_idx_d;
  logic [CHAR_W-1:0]        char_idx, char_idx_d;
  logic [DIGIT_COUNT*4-1:0] snapshot, snapshot_d;
  logic                     tx_d, busy_d, done_d;
  logic [3:0]               nibble;
  logic [7:0]               cur_char;
  logic                     bit_end;

  // Character currently being sent: a hex digit from the snapshot, or the CR/LF trailer
  always_comb begin
    nibble = '0;
    for (int k = 0; k < DIGIT_COUNT; k++) begin
      if (char_idx == CHAR_W'(k)) nibble = snapshot[4*k +: 4];
    end
    if (char_idx < CHAR_CR) begin
      cur_char = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    end else if (char_idx == CHAR_CR) begin
      cur_char = 8'h0D;
    end else begin
      cur_char = 8'h0A;
    end
  end

  assign bit_end = (baud == BAUD_LAST);

  // Next-state and next-output logic; the line level is computed here and registered below
  always_comb begin
    state_d    = state;
    baud_d     = bit_end ? '0 : baud + 1'b1;
    bit_idx_d  = bit_idx;
    char_idx_d = char_idx;
    snapshot_d = snapshot;
    tx_d       = RsTx;
    busy_d     = busy;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d    = START_BIT;
          snapshot_d = data_in;
          char_idx_d = '0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          state_d   = DATA_BITS;
          bit_idx_d = '0;
          tx_d      = cur_char[0];
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            tx_d      = cur_char[bit_idx + 3'd1];
          end
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          if (char_idx == CHAR_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = START_BIT;
            char_idx_d = char_idx + 1'b1;
            tx_d       = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any message in flight without a done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      snapshot <= '0;
      RsTx     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      baud     <= baud_d;
      bit_idx  <= bit_idx_d;
      char_idx <= char_idx_d;
      snapshot <= snapshot_d;
      RsTx     <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_hex_transmitter.sv
// tb/tb_uart_hex_transmitter.sv - directed self-checking bench for uart_hex_transmitter
module tb_uart_hex_transmitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = '0;
  logic        start = 1'b0;
  logic        tx, busy, done;
  logic [7:0]  data2 = '0;
  logic        start2 = 1'b0;
  logic        tx2, busy2, done2;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  uart_hex_transmitter #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000), .DIGIT_COUNT(4), .APPEND_CRLF(1)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .start(start), .RsTx(tx), .busy(busy), .done(done)
  );

  uart_hex_transmitter #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000), .DIGIT_COUNT(2), .APPEND_CRLF(0)) dut2 (
    .clk(clk), .reset(reset), .data_in(data2), .start(start2), .RsTx(tx2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  int   done_cnt = 0, last_done_cyc = 0, prev_done_cyc = 0, rise_cyc = 0, busy_cyc = 0, done_tx_bad = 0;
  int   done2_cnt = 0, busy2_cyc = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt      <= done_cnt + 1;
      prev_done_cyc <= last_done_cyc;
      last_done_cyc <= cyc;
      if (tx !== 1'b1) done_tx_bad <= done_tx_bad + 1;
    end
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    if (busy === 1'b1 && busy_prev !== 1'b1) rise_cyc <= cyc;
    busy_prev <= busy;
    if (done2 === 1'b1) done2_cnt <= done2_cnt + 1;
    if (busy2 === 1'b1) busy2_cyc <= busy2_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic line_of(input int which);
    return (which == 0) ? tx : tx2;
  endfunction

  task automatic rx_char(input int which, output logic [7:0] c, output logic ok);
    int n;
    ok = 1'b1;
    c  = '0;
    n  = 0;
    @(negedge clk);
    while (line_of(which) !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      ok = 1'b0;
      return;
    end
    repeat (4) @(negedge clk);
    if (line_of(which) !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      c[i] = line_of(which);
    end
    repeat (10) @(negedge clk);
    if (line_of(which) !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_msg(input int which, input logic [47:0] exp, input int n, input string tag);
    logic [7:0] c;
    logic       ok;
    for (int i = 0; i < n; i++) begin
      rx_char(which, c, ok);
      check($sformatf("%s_frame%0d", tag, i), {31'd0, ok}, 32'd1);
      check($sformatf("%s_char%0d", tag, i), {24'd0, c}, {24'd0, exp[8*i +: 8]});
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int d0, b0, bad0, d2, b2;

    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tx2", {31'd0, tx2}, 32'd1);
    reset = 1'b0;

    // basic message 4A3F -> F 3 A 4 CR LF
    settle(2);
    d0 = done_cnt; b0 = busy_cyc;
    check("idle_tx", {31'd0, tx}, 32'd1);
    data_in = 16'h4A3F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("tx_fall", {31'd0, tx}, 32'd0);
    check("busy_rise", {31'd0, busy}, 32'd1);
    rx_msg(0, 48'h0A0D_3441_3346, 6, "basic");
    settle(10);
    check("basic_busy_len", busy_cyc - b0, 32'd600);
    check("basic_done_cnt", done_cnt - d0, 32'd1);
    check("basic_done_at", last_done_cyc - rise_cyc, 32'd600);

    // snapshot and ignored start while busy
    d0 = done_cnt; b0 = busy_cyc;
    data_in = 16'h0009; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fork
      begin
        repeat (48) @(negedge clk);
        data_in = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      rx_msg(0, 48'h0A0D_3030_3039, 6, "snap");
    join
    settle(10);
    check("snap_done_cnt", done_cnt - d0, 32'd1);
    check("snap_busy_len", busy_cyc - b0, 32'd600);

    // reset in the middle of the second character
    d0 = done_cnt;
    data_in = 16'h4A3F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (134) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    settle(20);
    check("midrst_no_done", done_cnt - d0, 32'd0);
    check("midrst_idle_tx", {31'd0, tx}, 32'd1);
    d0 = done_cnt;
    data_in = 16'hC0DE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rx_msg(0, 48'h0A0D_4330_4445, 6, "after_rst");
    settle(10);
    check("after_rst_done", done_cnt - d0, 32'd1);

    // start held high: two back-to-back messages
    d0 = done_cnt; bad0 = done_tx_bad;
    data_in = 16'h1234; start = 1'b1;
    rx_msg(0, 48'h0A0D_3132_3334, 6, "b2b_a");
    rx_msg(0, 48'h0A0D_3132_3334, 6, "b2b_b");
    start = 1'b0;
    settle(10);
    check("b2b_done_cnt", done_cnt - d0, 32'd2);
    check("b2b_gap", rise_cyc - prev_done_cyc, 32'd1);
    check("b2b_len", last_done_cyc - rise_cyc, 32'd600);
    check("b2b_done_tx", done_tx_bad - bad0, 32'd0);
    check("b2b_idle_after", {31'd0, busy}, 32'd0);

    // two digits, no CR LF: B0 -> '0' 'B'
    d2 = done2_cnt; b2 = busy2_cyc;
    data2 = 8'hB0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    rx_msg(1, 48'h0000_0000_4230, 2, "two");
    settle(10);
    check("two_busy_len", busy2_cyc - b2, 32'd200);
    check("two_done_cnt", done2_cnt - d2, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
